// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port RAM,
// one access per two cycles, with a starvation bound for the fetch port.
//
// state | meaning
// IDLE  | no access in flight; a request may be accepted
// ISSUE | RAM access for the accepted request; read data captured at the edge
// RESP  | response presented for one cycle; a new request may be accepted
module mem_arbiter #(
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_wen,
  input  logic [63:0] d_req_wdata,
  input  logic [63:0] d_req_wmask,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_rdata,
  output logic        mem_en,
  output logic [63:0] mem_idx,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic [63:0] mem_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve_cnt;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [63:0]   r_wmask;
  logic          r_wen;
  logic          r_is_i;
  logic          r_i_resp_valid;
  logic          r_d_resp_valid;
  logic [31:0]   r_i_resp_data;
  logic [63:0]   r_d_resp_rdata;

  logic          w_eligible;
  logic          w_grant_i;
  logic          w_accept_i;
  logic          w_accept_d;
  logic          w_accept;
  logic          w_issue;
  logic [63:0]   w_idx;

  assign w_eligible = !reset && ((r_state == IDLE) || (r_state == RESP));
  assign w_grant_i  = i_req_valid && (!d_req_valid || (r_starve_cnt == LIMIT));
  assign w_accept_i = w_eligible && w_grant_i;
  assign w_accept_d = w_eligible && !w_grant_i && d_req_valid;
  assign w_accept   = w_accept_i || w_accept_d;
  // Reset gates the access combinationally so an in-flight write never commits.
  assign w_issue    = !reset && (r_state == ISSUE);
  assign w_idx      = (r_addr - BASE_ADDR) >> 3;

  assign i_req_ready  = w_eligible && w_grant_i;
  assign d_req_ready  = w_eligible && !w_grant_i;

  assign mem_en       = w_issue;
  assign mem_wen      = w_issue && r_wen;
  assign mem_idx      = w_issue ? w_idx : 64'd0;
  assign mem_wdata    = w_issue ? r_wdata : 64'd0;
  assign mem_wmask    = w_issue ? r_wmask : 64'd0;

  assign i_resp_valid = r_i_resp_valid && !reset;
  assign d_resp_valid = r_d_resp_valid && !reset;
  assign i_resp_data  = reset ? 32'd0 : r_i_resp_data;
  assign d_resp_rdata = reset ? 64'd0 : r_d_resp_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_starve_cnt   <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wmask        <= '0;
      r_wen          <= 1'b0;
      r_is_i         <= 1'b0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_i_resp_data  <= '0;
      r_d_resp_rdata <= '0;
    end else begin
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_i_resp_data  <= '0;
      r_d_resp_rdata <= '0;

      if (w_eligible) begin
        if (!i_req_valid || w_accept_i) begin
          r_starve_cnt <= '0;
        end else if (w_accept_d && (r_starve_cnt != LIMIT)) begin
          r_starve_cnt <= r_starve_cnt + SW'(1);
        end
      end

      if (w_accept) begin
        r_addr  <= w_accept_i ? i_req_addr : d_req_addr;
        r_is_i  <= w_accept_i;
        r_wen   <= w_accept_d && d_req_wen;
        r_wdata <= w_accept_d ? d_req_wdata : 64'd0;
        r_wmask <= w_accept_d ? d_req_wmask : 64'd0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= ISSUE;
        end
        ISSUE: begin
          r_state        <= RESP;
          r_i_resp_valid <= r_is_i;
          r_d_resp_valid <= !r_is_i;
          r_i_resp_data  <= !r_is_i ? 32'd0 :
                            (r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]);
          // Write acks return zero data; reads return the whole word unaligned.
          r_d_resp_rdata <= (r_is_i || r_wen) ? 64'd0 : mem_rdata;
        end
        RESP: begin
          r_state <= w_accept ? ISSUE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (accept -> access +1 -> response +2).
module tb_mem_arbiter;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          LIM  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [63:0] i_req_addr;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [63:0] d_req_addr;
  logic        d_req_wen;
  logic [63:0] d_req_wdata;
  logic [63:0] d_req_wmask;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;
  logic        mem_en;
  logic [63:0] mem_idx;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] ram [0:255] = '{default: 64'd0};

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_idx[7:0]];
  always @(posedge clk) begin
    if (mem_en && mem_wen)
      ram[mem_idx[7:0]] <= (ram[mem_idx[7:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  mem_arbiter #(.BASE_ADDR(BASE), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_en(mem_en), .mem_idx(mem_idx), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    i_req_valid = 0; i_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_wen = 0; d_req_wdata = 0; d_req_wmask = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    repeat (2) next_cycle();
    reset = 0;
  endtask

  // Preload a RAM word through the data port; returns in IDLE.
  task automatic write_word(input logic [63:0] a, input logic [63:0] w);
    d_req_valid = 1; d_req_wen = 1; d_req_addr = a; d_req_wdata = w; d_req_wmask = '1;
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1;
    i_req_valid = 1; i_req_addr = BASE;
    d_req_valid = 1; d_req_addr = BASE; d_req_wen = 1; d_req_wdata = '1; d_req_wmask = '1;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if ({i_req_ready, d_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {i_req_ready, d_req_ready}); end
    checks++; if ({mem_en, mem_wen} !== 2'b00) begin errors++; $display("FAIL reset_mem_en got %b exp 00", {mem_en, mem_wen}); end
    checks++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", {i_resp_valid, d_resp_valid}); end
    checks++; if ((mem_idx | mem_wdata | mem_wmask | d_resp_rdata | {32'd0, i_resp_data}) !== 64'd0) begin
      errors++; $display("FAIL reset_data idx %h wd %h wm %h dr %h ir %h exp all 0", mem_idx, mem_wdata, mem_wmask, d_resp_rdata, i_resp_data);
    end
    next_cycle();
    reset = 0; d_req_valid = 0; d_req_wen = 0;
    @(negedge clk);
    checks++; if ({i_req_ready, d_req_ready} !== 2'b10) begin errors++; $display("FAIL post_reset_ready got %b exp 10", {i_req_ready, d_req_ready}); end
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_fetch();
    do_reset();
    write_word(BASE, 64'h1122334455667788);
    i_req_valid = 1; i_req_addr = 64'h8000_0004;
    @(negedge clk);
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got %b exp 1", i_req_ready); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if ({mem_en, mem_wen} !== 2'b10) begin errors++; $display("FAIL fetch_mem_en got %b exp 10", {mem_en, mem_wen}); end
    checks++; if (mem_idx !== 64'd0) begin errors++; $display("FAIL fetch_idx got %h exp 0", mem_idx); end
    checks++; if (i_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_resp got %b exp 0", i_resp_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (i_resp_valid !== 1'b1) begin errors++; $display("FAIL fetch_resp_valid got %b exp 1", i_resp_valid); end
    checks++; if (i_resp_data !== 32'h11223344) begin errors++; $display("FAIL fetch_data got %h exp 11223344", i_resp_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (i_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_resp_one_cycle got %b exp 0", i_resp_valid); end
  endtask

  task automatic test_write_read();
    do_reset();
    d_req_valid = 1; d_req_wen = 1; d_req_addr = 64'h8000_0010;
    d_req_wdata = 64'hDEADBEEF_CAFEF00D; d_req_wmask = '1;
    @(negedge clk);
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", d_req_ready); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if ({mem_en, mem_wen} !== 2'b11) begin errors++; $display("FAIL wr_mem_en got %b exp 11", {mem_en, mem_wen}); end
    checks++; if (mem_idx !== 64'd2) begin errors++; $display("FAIL wr_idx got %h exp 2", mem_idx); end
    checks++; if (mem_wdata !== 64'hDEADBEEF_CAFEF00D || mem_wmask !== '1) begin errors++; $display("FAIL wr_payload got %h/%h exp deadbeefcafef00d/all-ones", mem_wdata, mem_wmask); end
    next_cycle();
    d_req_valid = 1; d_req_wen = 0; d_req_addr = 64'h8000_0010;
    @(negedge clk);
    checks++; if (d_resp_valid !== 1'b1 || d_resp_rdata !== 64'd0) begin errors++; $display("FAIL wr_ack got v=%b d=%h exp v=1 d=0", d_resp_valid, d_resp_rdata); end
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_in_resp got %b exp 1", d_req_ready); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (mem_idx !== 64'd2 || mem_wen !== 1'b0) begin errors++; $display("FAIL rd_issue got idx %h wen %b exp idx 2 wen 0", mem_idx, mem_wen); end
    next_cycle();
    @(negedge clk);
    checks++; if (d_resp_valid !== 1'b1 || d_resp_rdata !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL rd_data got v=%b d=%h exp v=1 d=deadbeefcafef00d", d_resp_valid, d_resp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_issue();
    do_reset();
    write_word(64'h8000_0008, 64'h0123_4567_89AB_CDEF);
    d_req_valid = 1; d_req_wen = 1; d_req_addr = 64'h8000_0008;
    d_req_wdata = 64'hFFFF_0000_FFFF_0000; d_req_wmask = '1;
    next_cycle(); idle_inputs();
    reset = 1;
    @(negedge clk);
    checks++; if ({mem_en, mem_wen} !== 2'b00) begin errors++; $display("FAIL abort_mem_wen got %b exp 00", {mem_en, mem_wen}); end
    next_cycle();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_resp cycle %0d got %b exp 0", k, d_resp_valid); end
      next_cycle();
    end
    checks++; if (ram[1] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL abort_ram1 got %h exp 0123456789abcdef", ram[1]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    d_req_valid = 1; d_req_wen = 0; d_req_addr = 64'h8000_0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (i_req_ready && d_req_ready) begin errors++; $display("FAIL b2b_both_ready cycle %0d got 11 exp not both", c); end
      if (c == 2 || c == 4) begin
        checks++; if (d_resp_valid !== 1'b1 || d_resp_rdata !== ((c == 2) ? 64'h1122334455667788 : 64'h0123456789ABCDEF)) begin
          errors++; $display("FAIL b2b_resp cycle %0d got v=%b d=%h", c, d_resp_valid, d_resp_rdata);
        end
      end else begin
        checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap cycle %0d got %b exp 0", c, d_resp_valid); end
      end
      next_cycle();
      if (c == 0) d_req_valid = 0;
      if (c == 1) begin d_req_valid = 1; d_req_addr = 64'h8000_0008; end
      if (c == 2) d_req_valid = 0;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    i_req_valid = 1; i_req_addr = 64'h7FFF_FFF8;
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++; if (mem_idx !== 64'h1FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_idx got %h exp 1fffffffffffffff", mem_idx); end
    repeat (2) next_cycle();
  endtask

  task automatic test_contention();
    int grants;
    logic exp_i;
    do_reset();
    grants = 0;
    i_req_valid = 1; i_req_addr = BASE;
    d_req_valid = 1; d_req_addr = BASE + 64'd8; d_req_wen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++; if (i_req_ready && d_req_ready) begin errors++; $display("FAIL contention_both_ready cycle %0d", c); end
      if (i_req_ready || d_req_ready) begin
        exp_i = (grants % (LIM + 1)) == LIM;
        checks++; if (i_req_ready !== exp_i) begin errors++; $display("FAIL contention_grant %0d got i=%b exp i=%b", grants, i_req_ready, exp_i); end
        grants++;
      end
      next_cycle();
    end
    checks++; if (grants !== 15) begin errors++; $display("FAIL contention_count got %0d exp 15", grants); end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_random();
    logic [63:0] shadow [0:255];
    int          la_c, starve;
    logic        la_is_i, la_wen, iv, dv, dw, elig, exp_gi, exp_gd;
    logic [63:0] la_idx, la_exp, ia, da, wd, wm, a, word;
    do_reset();
    for (int k = 0; k < 256; k++) shadow[k] = ram[k];
    la_c = -100; starve = 0; la_is_i = 0; la_wen = 0; la_idx = 0; la_exp = 0;
    for (int c = 0; c < 400; c++) begin
      iv = ($urandom_range(0, 9) < 7);
      dv = ($urandom_range(0, 9) < 7);
      ia = BASE + 64'($urandom_range(0, 15)) * 8 + (($urandom_range(0, 1) == 1) ? 64'd4 : 64'd0);
      da = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      dw = ($urandom_range(0, 2) == 0);
      wd = {$urandom, $urandom}; wm = {$urandom, $urandom};
      i_req_valid = iv; i_req_addr = ia;
      d_req_valid = dv; d_req_addr = da; d_req_wen = dw; d_req_wdata = wd; d_req_wmask = wm;
      @(negedge clk);
      elig   = (c - la_c) >= 2;
      exp_gi = elig && iv && (!dv || starve == LIM);
      exp_gd = elig && dv && !exp_gi;
      checks++; if (i_req_ready !== exp_gi) begin errors++; $display("FAIL rnd_i_ready cycle %0d got %b exp %b", c, i_req_ready, exp_gi); end
      if (dv) begin
        checks++; if (d_req_ready !== exp_gd) begin errors++; $display("FAIL rnd_d_ready cycle %0d got %b exp %b", c, d_req_ready, exp_gd); end
      end
      checks++; if (i_req_ready && d_req_ready) begin errors++; $display("FAIL rnd_both_ready cycle %0d", c); end
      if (c - la_c == 1) begin
        checks++; if (mem_en !== 1'b1 || mem_idx !== la_idx || mem_wen !== la_wen) begin
          errors++; $display("FAIL rnd_access cycle %0d got en=%b idx=%h wen=%b exp en=1 idx=%h wen=%b", c, mem_en, mem_idx, mem_wen, la_idx, la_wen);
        end
      end else begin
        checks++; if ({mem_en, mem_wen} !== 2'b00) begin errors++; $display("FAIL rnd_no_access cycle %0d got %b exp 00", c, {mem_en, mem_wen}); end
      end
      if (c - la_c == 2) begin
        if (la_is_i) begin
          checks++; if (i_resp_valid !== 1'b1 || d_resp_valid !== 1'b0 || i_resp_data !== la_exp[31:0]) begin
            errors++; $display("FAIL rnd_i_resp cycle %0d got v=%b%b d=%h exp v=10 d=%h", c, i_resp_valid, d_resp_valid, i_resp_data, la_exp[31:0]);
          end
        end else begin
          checks++; if (d_resp_valid !== 1'b1 || i_resp_valid !== 1'b0 || d_resp_rdata !== la_exp) begin
            errors++; $display("FAIL rnd_d_resp cycle %0d got v=%b%b d=%h exp v=01 d=%h", c, i_resp_valid, d_resp_valid, d_resp_rdata, la_exp);
          end
        end
      end else begin
        checks++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin errors++; $display("FAIL rnd_no_resp cycle %0d got %b exp 00", c, {i_resp_valid, d_resp_valid}); end
      end
      if (exp_gi || exp_gd) begin
        la_c = c; la_is_i = exp_gi;
        a = exp_gi ? ia : da;
        la_idx = (a - BASE) >> 3;
        word = shadow[la_idx[7:0]];
        la_wen = exp_gd && dw;
        if (exp_gi) la_exp = {32'd0, a[2] ? word[63:32] : word[31:0]};
        else if (dw) begin
          la_exp = 64'd0;
          shadow[la_idx[7:0]] = (word & ~wm) | (wd & wm);
        end else la_exp = word;
      end
      if (elig) begin
        if (!iv || exp_gi) starve = 0;
        else if (exp_gd && starve < LIM) starve++;
      end
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_write_read();
    test_reset_issue();
    test_back_to_back();
    test_wrap();
    test_contention();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, the physical address of RAM word 0.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, the maximum consecutive instruction-port losses before it is forced a grant.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports i_req_valid input 1, i_req_ready output 1, i_req_addr input 64  for instruction-fetch requests.
REQ-006 The block SHALL have ports i_resp_valid output 1, i_resp_data output 32  for the selected fetch word.
REQ-007 The block SHALL have ports d_req_valid input 1, d_req_ready output 1, d_req_addr input 64, d_req_wen input 1, d_req_wdata input 64, d_req_wmask input 64  for data requests.
REQ-008 The block SHALL have ports d_resp_valid output 1, d_resp_rdata output 64  for data responses.
REQ-009 The block SHALL have ports mem_en output 1, mem_idx output 64, mem_wen output 1, mem_wdata output 64, mem_wmask output 64, mem_rdata input 64  to the single-port RAM; mem_rdata is combinational on mem_idx within the same cycle, and a write commits at the clock edge.

Function
REQ-010 A request SHALL be accepted in a cycle where its valid and ready are both high.
REQ-011 FSM states SHALL be IDLE, ISSUE and RESP; IDLE->ISSUE on accept, ISSUE->RESP unconditionally, RESP->ISSUE on accept, else RESP->IDLE.
REQ-012 i_req_ready and d_req_ready SHALL be high only in IDLE or RESP, and at most one SHALL be high in any cycle.
REQ-013 Arbitration: when only one port is valid, that port SHALL be granted.
REQ-014 When both ports are valid, the data port SHALL be granted unless starve_cnt == STARVE_LIMIT, in which case the instruction port SHALL be granted.
REQ-015 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each accept cycle where i_req_valid is high and data is granted.
REQ-016 starve_cnt SHALL clear when the instruction port is granted or when i_req_valid is low in an accept-eligible state.
REQ-017 Accepted address, wen, wdata, wmask and requester id SHALL be registered; the request payload SHALL be ignored after acceptance.
REQ-018 In ISSUE, mem_en SHALL be 1 and mem_idx SHALL be {3'b000, (addr - BASE_ADDR) >> 3}, using 64-bit wrap-around subtraction.
REQ-019 In ISSUE, mem_wen SHALL be 1 only for a data write; mem_wdata and mem_wmask SHALL be the registered values.
REQ-020 Outside ISSUE, mem_en and mem_wen SHALL be 0.
REQ-021 mem_rdata SHALL be captured at the end of ISSUE.
REQ-022 The response SHALL be presented for exactly one cycle in RESP, two cycles after acceptance.
REQ-023 Responses have no backpressure; requesters SHALL accept them.
REQ-024 Instruction response: i_resp_data SHALL be the captured data [63:32] if addr[2]=1, else [31:0].
REQ-025 Data read response: d_resp_rdata SHALL be the full captured 64-bit word; addr[2:0] is ignored (requester aligns).
REQ-026 Data write response: d_resp_valid=1 serves as the write ack, and d_resp_rdata SHALL be 0.
REQ-027 Back-to-back operation: an accept in RESP SHALL deliver the current response and begin the next access, sustaining one access per two cycles.
REQ-028 Simultaneous write followed by a read of the same index SHALL return the newly written data, because the write commits at the end of ISSUE.

Reset
REQ-029 While reset=1: state SHALL be IDLE, starve_cnt=0, all *_ready=0, *_resp_valid=0, mem_en=0, mem_wen=0, and all data outputs SHALL be 0.
REQ-030 Reset asserted in ISSUE or RESP SHALL abort the transaction, suppress its response, and block any RAM write in that cycle.
REQ-031 Ready SHALL assert in the first cycle after reset deasserts if the block is in IDLE.

Verification
REQ-032 Fetch: i_req addr 0x8000_0004, RAM[0]=0x1122334455667788 -> mem_idx=0 in cycle+1; i_resp_valid in cycle+2 with data 0x11223344.
REQ-033 Write then read: d write addr 0x8000_0010, wdata 0xDEADBEEF_CAFEF00D, wmask all-ones; then d read of the same address -> mem_idx=2, ack with rdata 0, then read returns 0xDEADBEEFCAFEF00D.
REQ-034 Contention: both ports valid continuously with STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; starve_cnt returns to 0 after each I grant.
REQ-035 Reset in ISSUE of a write to 0x8000_0008 -> mem_wen=0 in that cycle, no d_resp_valid, RAM[1] unchanged.
REQ-036 Back-to-back reads at 0x8000_0000 and 0x8000_0008 -> responses 2 cycles apart; no cycle with both ready signals high.
REQ-037 Address below base, 0x7FFF_FFF8 -> mem_idx=64'h1FFF_FFFF_FFFF_FFFF; the bench SHALL check the wrap-around index only.
